// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encodings, LCD command constants and init ROM for lcd_ctrl_param
package lcd_pkg;

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, XFER, WAIT} ctrl_state_t;
  typedef enum logic [1:0] {PHY_IDLE, SETUP, EN_HI, HOLD} phy_state_t;

  localparam logic [7:0] CLR      = 8'h01;
  localparam logic [7:0] HOME     = 8'h02;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DISP_OFF = 8'h08;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] FUNC_8B  = 8'h38;
  localparam logic [7:0] FUNC_4B  = 8'h28;
  localparam logic [7:0] WAKE     = 8'h30;
  localparam logic [7:0] GO_4B    = 8'h20;

  localparam int INIT_LEN_8 = 8;
  localparam int INIT_LEN_4 = 9;

  // single: only the high nibble goes out in 4-bit mode (the wake-up writes)
  typedef struct packed {
    logic       long_wait;
    logic       single;
    logic [7:0] cmd;
  } init_entry_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

  function automatic init_entry_t init_rom(input logic four, input logic [3:0] idx);
    init_entry_t e;
    e = '{1'b0, 1'b0, 8'h00};
    if (four) begin
      case (idx)
        4'd0, 4'd1, 4'd2: e = '{1'b1, 1'b1, WAKE};
        4'd3:             e = '{1'b0, 1'b1, GO_4B};
        4'd4:             e = '{1'b0, 1'b0, FUNC_4B};
        4'd5:             e = '{1'b0, 1'b0, DISP_OFF};
        4'd6:             e = '{1'b1, 1'b0, CLR};
        4'd7:             e = '{1'b0, 1'b0, ENTRY};
        4'd8:             e = '{1'b0, 1'b0, DISP_ON};
        default:          e = '{1'b0, 1'b0, 8'h00};
      endcase
    end else begin
      case (idx)
        4'd0, 4'd1, 4'd2: e = '{1'b1, 1'b0, WAKE};
        4'd3:             e = '{1'b0, 1'b0, FUNC_8B};
        4'd4:             e = '{1'b0, 1'b0, DISP_OFF};
        4'd5:             e = '{1'b1, 1'b0, CLR};
        4'd6:             e = '{1'b0, 1'b0, ENTRY};
        4'd7:             e = '{1'b0, 1'b0, DISP_ON};
        default:          e = '{1'b0, 1'b0, 8'h00};
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/lcd_bus_phy.sv
// rtl/lcd_bus_phy.sv - one SETUP/EN_HI/HOLD strobe cycle on the LCD bus with start/done handshake
module lcd_bus_phy
  import lcd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start,
  input  logic              rs,
  input  logic [DATA_W-1:0] word,
  output logic              done,
  output logic              reg_sel,
  output logic              enable,
  output logic [DATA_W-1:0] bus
);

  localparam int CNT_W = cnt_width(SETUP_CYC, EN_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_CYC - 1);

  phy_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              en_q, en_n, rs_q, rs_n;
  logic [DATA_W-1:0] bus_q, bus_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= PHY_IDLE;
      cnt   <= '0;
      en_q  <= 1'b0;
      rs_q  <= 1'b0;
      bus_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      en_q  <= en_n;
      rs_q  <= rs_n;
      bus_q <= bus_n;
    end
  end

  // A start during the last HOLD cycle chains straight into the next SETUP
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    en_n    = en_q;
    rs_n    = rs_q;
    bus_n   = bus_q;
    case (state)
      PHY_IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = SETUP;
          rs_n    = rs;
          bus_n   = word;
        end
      end
      SETUP: if (cnt == S_LAST) begin
        state_n = EN_HI;
        cnt_n   = '0;
        en_n    = 1'b1;
      end
      EN_HI: if (cnt == E_LAST) begin
        state_n = HOLD;
        cnt_n   = '0;
        en_n    = 1'b0;
      end
      HOLD: if (cnt == H_LAST) begin
        cnt_n = '0;
        if (start) begin
          state_n = SETUP;
          rs_n    = rs;
          bus_n   = word;
        end else begin
          state_n = PHY_IDLE;
        end
      end
      default: state_n = PHY_IDLE;
    endcase
  end

  assign done    = (state == HOLD) && (cnt == H_LAST);
  assign reg_sel = rs_q;
  assign enable  = en_q;
  assign bus     = bus_q;

endmodule

// File: rtl/lcd_ctrl_param.sv
// rtl/lcd_ctrl_param.sv - HD44780 write controller; define LCD_INIT_EN to play the power-on init ROM
module lcd_ctrl_param
  import lcd_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SETUP_CYC     = 4,
  parameter int EN_CYC        = 25,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000,
  parameter int PWRUP_CYC     = 750000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              rs_i,
  input  logic [7:0]        data_i,
  output logic              ready_o,
  output logic              init_done_o,
  output logic              reg_sel_o,
  output logic              enable_o,
  output logic [DATA_W-1:0] lcd_data_o
);

  localparam bit FOUR  = (DATA_W == 4);
  localparam int CNT_W = cnt_width(PWRUP_CYC, LONG_WAIT_CYC, WAIT_CYC);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_WAIT_CYC - 1);

  ctrl_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              init_done_q, init_done_n;
  logic [7:0]        data_q, data_n;
  logic              rs_q, rs_n, long_q, long_n, single_q, single_n, nib_q, nib_n;
  logic              start, rs_src, phy_done;
  logic [7:0]        word_src;
  logic [DATA_W-1:0] bus_word;

`ifdef LCD_INIT_EN
  localparam int INIT_LEN = FOUR ? INIT_LEN_4 : INIT_LEN_8;
  localparam logic [3:0] INIT_LAST = 4'(INIT_LEN - 1);
  logic [3:0]  idx, idx_n;
  init_entry_t rom;
  assign rom = init_rom(FOUR, idx);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= PWRUP;
      cnt         <= '0;
      init_done_q <= 1'b0;
      data_q      <= '0;
      rs_q        <= 1'b0;
      long_q      <= 1'b0;
      single_q    <= 1'b0;
      nib_q       <= 1'b0;
`ifdef LCD_INIT_EN
      idx         <= '0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      init_done_q <= init_done_n;
      data_q      <= data_n;
      rs_q        <= rs_n;
      long_q      <= long_n;
      single_q    <= single_n;
      nib_q       <= nib_n;
`ifdef LCD_INIT_EN
      idx         <= idx_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    init_done_n = init_done_q;
    data_n      = data_q;
    rs_n        = rs_q;
    long_n      = long_q;
    single_n    = single_q;
    nib_n       = nib_q;
    start       = 1'b0;
    word_src    = data_q;
    rs_src      = rs_q;
`ifdef LCD_INIT_EN
    idx_n       = idx;
`endif
    case (state)
      PWRUP: begin
        if (cnt == PWR_LAST) begin
          cnt_n = '0;
`ifdef LCD_INIT_EN
          state_n = INIT;
`else
          state_n     = IDLE;
          init_done_n = 1'b1;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef LCD_INIT_EN
      INIT: begin
        start    = 1'b1;
        word_src = rom.cmd;
        rs_src   = 1'b0;
        data_n   = rom.cmd;
        rs_n     = 1'b0;
        long_n   = rom.long_wait;
        single_n = rom.single;
        nib_n    = 1'b0;
        state_n  = XFER;
      end
`endif
      // The accept edge loads the PHY directly so the bus changes in the next cycle
      IDLE: begin
        word_src = data_i;
        rs_src   = rs_i;
        if (valid_i && init_done_q) begin
          start    = 1'b1;
          data_n   = data_i;
          rs_n     = rs_i;
          long_n   = !rs_i && (data_i[7:2] == 6'd0);
          single_n = 1'b0;
          nib_n    = 1'b0;
          state_n  = XFER;
        end
      end
      XFER: begin
        if (phy_done) begin
          if (FOUR && !nib_q && !single_q) begin
            start = 1'b1;
            nib_n = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = '0;
          end
        end
      end
      WAIT: begin
        if (cnt == (long_q ? LONG_LAST : WAIT_LAST)) begin
          cnt_n   = '0;
          state_n = IDLE;
`ifdef LCD_INIT_EN
          if (!init_done_q) begin
            if (idx == INIT_LAST) begin
              init_done_n = 1'b1;
            end else begin
              idx_n   = idx + 1'b1;
              state_n = INIT;
            end
          end
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  // The second nibble is the only transfer started from XFER
  if (DATA_W == 8) begin : g_bus8
    assign bus_word = word_src;
  end else if (DATA_W == 4) begin : g_bus4
    assign bus_word = (state == XFER) ? word_src[3:0] : word_src[7:4];
  end else begin : g_bad_width
    $error("lcd_ctrl_param: DATA_W must be 8 or 4");
  end

  lcd_bus_phy #(
    .DATA_W   (DATA_W),
    .SETUP_CYC(SETUP_CYC),
    .EN_CYC   (EN_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) u_phy (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (start),
    .rs     (rs_src),
    .word   (bus_word),
    .done   (phy_done),
    .reg_sel(reg_sel_o),
    .enable (enable_o),
    .bus    (lcd_data_o)
  );

  assign ready_o     = (state == IDLE) && init_done_q;
  assign init_done_o = init_done_q;

endmodule
